// File: rtl/stage_if_if.sv
// Instruction-memory request/acknowledge port between the fetch stage and memory.
interface stage_if_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, addr, input ack, rdata);
  modport slave  (input req, addr, output ack, rdata);
endinterface

// File: rtl/stage_if.sv
// Instruction-fetch stage: owns the fetch PC, runs the imem handshake and feeds
// decode one instruction per cycle through an output register and a one-entry skid.
module stage_if #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_stall,
  input  logic        id_branch,
  input  logic [31:0] id_branch_dest,
  input  logic        exn,
  input  logic [31:0] exn_vector,
  stage_if_if.master  imem,
  output logic [31:0] pc,
  output logic [31:0] nextpc,
  output logic [31:0] instr,
  output logic        bubble,
  output logic        stall
);

  // S_DROP: a request is still in flight but a redirect has made its answer stale.
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DROP} req_state_e;

  req_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        bubble_q, bubble_d;
  logic        stall_q, stall_d;

  logic        redirect;
  logic [31:0] target_raw;
  logic [31:0] target;
  logic        accept;

  assign redirect   = exn | (id_branch & ~id_stall);
  assign target_raw = exn ? exn_vector : id_branch_dest;
  assign target     = target_raw & ~32'h3;
  assign accept     = (state_q == S_BUSY) & imem.ack & ~redirect;

  // NOTE: every variable gets a default before any branch so no path leaves
  // it unassigned; a missed path here would infer a latch.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    fetch_pc_d   = fetch_pc_q;
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    bubble_d     = bubble_q;
    stall_d      = stall_q;

    if (redirect) begin
      // An exception overrides decode's stall, so the output always reloads here.
      fetch_pc_d   = target;
      skid_valid_d = 1'b0;
      pc_d         = target;
      instr_d      = NOP_INSTR;
      bubble_d     = 1'b1;
      stall_d      = 1'b0;
      if (state_q != S_IDLE && !imem.ack) begin
        state_d = S_DROP;
      end else begin
        state_d = S_BUSY;
        addr_d  = target;
      end
    end else begin
      if (!id_stall) begin
        if (skid_valid_q) begin
          pc_d     = skid_pc_q;
          instr_d  = skid_instr_q;
          bubble_d = 1'b0;
          stall_d  = 1'b0;
        end else if (accept) begin
          pc_d     = addr_q;
          instr_d  = imem.rdata;
          bubble_d = 1'b0;
          stall_d  = 1'b0;
        end else begin
          pc_d     = fetch_pc_q;
          instr_d  = NOP_INSTR;
          bubble_d = 1'b1;
          stall_d  = 1'b1;
        end
      end

      if (accept && (id_stall || skid_valid_q)) begin
        skid_valid_d = 1'b1;
        skid_pc_d    = addr_q;
        skid_instr_d = imem.rdata;
      end else if (!id_stall) begin
        skid_valid_d = 1'b0;
      end

      if (accept) fetch_pc_d = fetch_pc_q + 32'd4;

      // A full skid parks the request port until decode drains it.
      case (state_q)
        S_IDLE: begin
          if (!skid_valid_d) begin
            state_d = S_BUSY;
            addr_d  = fetch_pc_q;
          end
        end
        S_BUSY: begin
          if (imem.ack) begin
            if (skid_valid_d) state_d = S_IDLE;
            else              addr_d  = fetch_pc_d;
          end
        end
        S_DROP: begin
          if (imem.ack) begin
            state_d = S_BUSY;
            addr_d  = fetch_pc_q;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= RESET_PC;
      fetch_pc_q   <= RESET_PC;
      skid_valid_q <= 1'b0;
      pc_q         <= RESET_PC;
      instr_q      <= NOP_INSTR;
      bubble_q     <= 1'b1;
      stall_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      fetch_pc_q   <= fetch_pc_d;
      skid_valid_q <= skid_valid_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      bubble_q     <= bubble_d;
      stall_q      <= stall_d;
    end
  end

  // NOTE: the skid payload is not reset; skid_valid_q alone qualifies it.
  always_ff @(posedge clk) begin
    skid_pc_q    <= skid_pc_d;
    skid_instr_q <= skid_instr_d;
  end

  assign imem.req  = (state_q != S_IDLE);
  assign imem.addr = addr_q;
  assign pc        = pc_q;
  assign nextpc    = pc_q + 32'd4;
  assign instr     = instr_q;
  assign bubble    = bubble_q;
  assign stall     = stall_q;

endmodule

// File: tb/tb_stage_if.sv
// Scoreboard bench for stage_if: expected pcs are queued per scenario and
// popped whenever decode would consume a valid instruction.
module tb_stage_if;
  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_stall = 1'b0;
  logic        id_branch = 1'b0;
  logic [31:0] id_branch_dest = '0;
  logic        exn = 1'b0;
  logic [31:0] exn_vector = '0;
  logic [31:0] pc, nextpc, instr;
  logic        bubble, stall;

  int          lat = 0;
  int          wcnt;
  logic        stray_ack = 1'b0;
  logic [31:0] exp_q[$];
  int          errors = 0;
  int          checks = 0;

  stage_if_if imem ();

  stage_if dut (
    .clk            (clk),
    .rst            (rst),
    .id_stall       (id_stall),
    .id_branch      (id_branch),
    .id_branch_dest (id_branch_dest),
    .exn            (exn),
    .exn_vector     (exn_vector),
    .imem           (imem),
    .pc             (pc),
    .nextpc         (nextpc),
    .instr          (instr),
    .bubble         (bubble),
    .stall          (stall)
  );

  always #5 clk = ~clk;

  // Memory model: acks after lat wait cycles, data derived from the address.
  assign imem.ack   = stray_ack | (imem.req && (wcnt >= lat));
  assign imem.rdata = imem.addr ^ KEY;

  always @(posedge clk or posedge rst) begin
    if (rst) wcnt <= 0;
    else if (imem.req && !imem.ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  task automatic do_reset();
    rst = 1'b1;
    id_stall = 1'b0; id_branch = 1'b0; exn = 1'b0;
    id_branch_dest = '0; exn_vector = '0;
    lat = 0; stray_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic tick();
    logic        held;
    logic [31:0] e;
    held = id_stall;
    @(posedge clk);
    #1;
    if (!held && bubble === 1'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_instr: got pc=%h instr=%h, required none", pc, instr);
      end else begin
        e = exp_q.pop_front();
        if (pc !== e || nextpc !== e + 32'd4 || instr !== (e ^ KEY)) begin
          errors++;
          $display("FAIL deliver: got pc=%h nextpc=%h instr=%h, required pc=%h nextpc=%h instr=%h",
                   pc, nextpc, instr, e, e + 32'd4, e ^ KEY);
        end
      end
    end
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing: got %0d undelivered, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (pc !== 32'h0 || nextpc !== 32'h4 || instr !== 32'h0 || bubble !== 1'b1 ||
        stall !== 1'b0 || imem.req !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got pc=%h nextpc=%h instr=%h bubble=%b stall=%b req=%b, required 0/4/0/1/0/0",
               pc, nextpc, instr, bubble, stall, imem.req);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (imem.req !== 1'b0) begin
      errors++;
      $display("FAIL req_before_edge: got req=%b, required 0", imem.req);
    end
  endtask

  task automatic test_stream();
    do_reset();
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    exp_q.push_back(32'h8); exp_q.push_back(32'hC);
    tick();
    checks++;
    if (imem.req !== 1'b1 || imem.addr !== 32'h0 || bubble !== 1'b1 || stall !== 1'b1) begin
      errors++;
      $display("FAIL first_req: got req=%b addr=%h bubble=%b stall=%b, required 1/0/1/1",
               imem.req, imem.addr, bubble, stall);
    end
    repeat (4) tick();
    check_drained("stream");
  endtask

  task automatic test_wait();
    logic [31:0] held_addr;
    logic        waiting;
    do_reset();
    lat = 3;
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    waiting = 1'b0;
    held_addr = '0;
    for (int i = 0; i < 13; i++) begin
      tick();
      if (waiting && imem.req === 1'b1) begin
        checks++;
        if (imem.addr !== held_addr) begin
          errors++;
          $display("FAIL addr_stable: got addr=%h, required %h", imem.addr, held_addr);
        end
      end
      if (i > 0 && bubble === 1'b1) begin
        checks++;
        if (stall !== 1'b1 || instr !== 32'h0) begin
          errors++;
          $display("FAIL wait_bubble: got stall=%b instr=%h, required 1/0", stall, instr);
        end
      end
      waiting   = imem.req && !imem.ack;
      held_addr = imem.addr;
    end
    check_drained("wait");
  endtask

  task automatic test_skid();
    do_reset();
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    exp_q.push_back(32'hC); exp_q.push_back(32'h10);
    repeat (3) tick();
    id_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (pc !== 32'h4 || bubble !== 1'b0 || imem.req !== 1'b0) begin
        errors++;
        $display("FAIL skid_hold: got pc=%h bubble=%b req=%b, required 4/0/0", pc, bubble, imem.req);
      end
    end
    id_stall = 1'b0;
    repeat (3) tick();
    check_drained("skid");
  endtask

  task automatic test_branch();
    do_reset();
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    exp_q.push_back(32'h8); exp_q.push_back(32'hC);
    repeat (5) tick();
    lat = 3;
    tick();
    id_branch = 1'b1;
    id_branch_dest = 32'h103;
    tick();
    id_branch = 1'b0;
    checks++;
    if (bubble !== 1'b1 || stall !== 1'b0 || imem.req !== 1'b1 || imem.addr !== 32'h10) begin
      errors++;
      $display("FAIL branch_edge: got bubble=%b stall=%b req=%b addr=%h, required 1/0/1/10",
               bubble, stall, imem.req, imem.addr);
    end
    exp_q.push_back(32'h100);
    repeat (2) tick();
    checks++;
    if (imem.req !== 1'b1 || imem.addr !== 32'h100) begin
      errors++;
      $display("FAIL branch_refetch: got req=%b addr=%h, required 1/100", imem.req, imem.addr);
    end
    repeat (4) tick();
    check_drained("branch");
  endtask

  task automatic test_exn();
    do_reset();
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    repeat (3) tick();
    id_stall = 1'b1;
    exn = 1'b1; exn_vector = 32'h80;
    id_branch = 1'b1; id_branch_dest = 32'h200;
    tick();
    id_stall = 1'b0; exn = 1'b0; id_branch = 1'b0;
    checks++;
    if (bubble !== 1'b1 || stall !== 1'b0 || imem.addr !== 32'h80) begin
      errors++;
      $display("FAIL exn_edge: got bubble=%b stall=%b addr=%h, required 1/0/80", bubble, stall, imem.addr);
    end
    exp_q.push_back(32'h80); exp_q.push_back(32'h84);
    repeat (2) tick();
    check_drained("exn");
  endtask

  task automatic test_wrap();
    do_reset();
    tick();
    exn = 1'b1; exn_vector = 32'hFFFF_FFFE;
    tick();
    exn = 1'b0;
    checks++;
    if (imem.addr !== 32'hFFFF_FFFC || bubble !== 1'b1) begin
      errors++;
      $display("FAIL wrap_target: got addr=%h bubble=%b, required fffffffc/1", imem.addr, bubble);
    end
    exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0);
    repeat (2) tick();
    check_drained("wrap");
  endtask

  task automatic test_reset_mid();
    do_reset();
    lat = 3;
    repeat (2) tick();
    rst = 1'b1;
    #1;
    checks++;
    if (imem.req !== 1'b0 || bubble !== 1'b1 || stall !== 1'b0 || pc !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset: got req=%b bubble=%b stall=%b pc=%h, required 0/1/0/0",
               imem.req, bubble, stall, pc);
    end
    @(posedge clk);
    #1;
    lat = 0;
    stray_ack = 1'b1;
    rst = 1'b0;
    exp_q.delete();
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    tick();
    stray_ack = 1'b0;
    checks++;
    if (imem.req !== 1'b1 || imem.addr !== 32'h0) begin
      errors++;
      $display("FAIL restart_req: got req=%b addr=%h, required 1/0", imem.req, imem.addr);
    end
    repeat (2) tick();
    check_drained("reset_mid");
  endtask

  initial begin
    test_reset();
    test_stream();
    test_wait();
    test_skid();
    test_branch();
    test_exn();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stage_if.md
Name: stage_if

Overview:
- Instruction-fetch stage: owns the fetch PC and issues word requests on a request/acknowledge instruction-memory port.
- Presents one instruction per cycle to the decode stage as pc/nextpc/instr/bubble/stall.
- Obeys decode's stall and redirects on decode branches and on exceptions.
- Contains a one-entry skid buffer so no instruction is lost or duplicated while decode stalls.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset
NOP_INSTR, 32'h0000_0000, instr value driven on bubbles

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
id_stall  input  1  decode holding its input; IF outputs must not advance
id_branch  input  1  decode redirect request (only asserted when decode not stalled)
id_branch_dest  input  32  redirect target
exn  input  1  exception redirect
exn_vector  input  32  exception target
imem_req  output  1  fetch request valid
imem_addr  output  32  word address of request, bits [1:0] always 0
imem_ack  input  1  memory accepted request; imem_rdata valid this cycle
imem_rdata  input  32  fetched instruction
pc  output  32  address of instr
nextpc  output  32  pc+4
instr  output  32  instruction word to decode
bubble  output  1  instr is not a valid instruction
stall  output  1  bubble caused by memory wait (decode uses pc, not nextpc)

Behaviour:
- Reset (async, any state):
  - pc=RESET_PC, nextpc=RESET_PC+4, instr=NOP_INSTR, bubble=1, stall=0.
  - imem_req=0, fetch_pc=RESET_PC, skid empty, discard=0.
- Request handshake:
  - imem_req rises the first clk edge after rst deasserts.
  - While imem_req=1 and imem_ack=0, imem_addr and imem_req are held stable.
  - imem_ack is sampled only when imem_req=1; zero-wait memory may ack in the same cycle as imem_req.
  - Each accepted response increments fetch_pc by 4, wrapping modulo 2^32.
- Output register advances only on edges where id_stall=0:
  - loads the skid entry if one is present, otherwise the current ack data;
  - otherwise loads a bubble: instr=NOP_INSTR, bubble=1, stall=1, pc=fetch_pc.
- While id_stall=1, the output register holds all values.
- Skid buffer:
  - If an ack arrives while id_stall=1, the data and its pc go into the skid entry.
  - imem_req deasserts after the current transaction while the skid entry is full.
  - Back-to-back acks with no stall give one instruction per cycle.
- Redirect:
  - Trigger is exn, or id_branch with id_stall=0. exn has priority over id_branch.
  - Target has bits [1:0] forced to 0.
  - On the redirect edge: fetch_pc=target; skid cleared; output becomes bubble=1, stall=0.
  - An exn redirect loads the output even if id_stall=1.
  - If a request is outstanding and not acked that cycle, discard is set. The next ack is dropped, discard clears, and the request to target issues the following cycle.
  - An ack in the same cycle as the redirect is dropped.
  - A new request to target starts the cycle after the redirect.
- Latency: with zero-wait memory, the instruction at fetch_pc appears at the outputs one edge after ack.
- nextpc is always pc+4, modulo 2^32.

Test Plan:
1. Release rst, memory always acks with rdata=addr^32'hA5A5_0000 -> outputs pc=0,4,8,C on consecutive cycles with bubble=0 from the second cycle; nextpc=pc+4.
2. Memory acks 3 cycles after req -> imem_addr constant across the wait; outputs bubble=1, stall=1 for waiting cycles; each instruction delivered exactly once in order.
3. id_stall=1 for 3 cycles while an ack for 0x8 arrives -> outputs hold pc=0x4; skid holds 0x8; imem_req low; after release, 0x8 then 0xC, no gaps beyond the refetch, no duplicates.
4. id_branch=1, id_branch_dest=0x103 while the request to 0x10 is outstanding -> 0x10 response dropped; next valid pc=0x100, instr from 0x100.
5. exn=1 (exn_vector=0x80) and id_branch=1 (dest 0x200) in the same cycle, with id_stall=1 -> next valid pc=0x80, bubble=1 the cycle after.
6. Assert rst mid-transaction with an outstanding request -> imem_req=0 immediately; after release, fetch restarts at RESET_PC; the stale ack is ignored.
